// File: rtl/dme_interrogation_scheduler.sv
// DME interrogator sequencer: releases the pulse-pair generator once per PRF
// period, times the reply listen window and runs search/track lock logic.
module dme_interrogation_scheduler #(
  parameter int CW            = 32,
  parameter int PULSE_W       = 35,
  parameter int X_SPACING     = 120,
  parameter int Y_SPACING     = 360,
  parameter int SEARCH_PERIOD = 6667,
  parameter int TRACK_PERIOD  = 40000,
  parameter int LISTEN_MAX    = 4000,
  parameter int LOCK_N        = 4,
  parameter int LOSE_M        = 8
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          enable,
  input  logic          chan_y,
  input  logic          reply_det,
  output logic          gen_resetn,
  output logic [CW-1:0] t1,
  output logic [CW-1:0] t2,
  output logic [CW-1:0] t3,
  output logic [CW-1:0] range_cnt,
  output logic          range_valid,
  output logic          locked
);

  typedef enum logic [1:0] {S_IDLE, S_TX, S_LISTEN, S_WAIT} state_e;

  localparam logic [CW-1:0] PW    = CW'(PULSE_W);
  localparam logic [CW-1:0] XSP   = CW'(X_SPACING);
  localparam logic [CW-1:0] YSP   = CW'(Y_SPACING);
  localparam logic [CW-1:0] SPER  = CW'(SEARCH_PERIOD);
  localparam logic [CW-1:0] TPER  = CW'(TRACK_PERIOD);
  localparam logic [CW-1:0] LMAX  = CW'(LISTEN_MAX);
  localparam logic [CW-1:0] LOCKN = CW'(LOCK_N);
  localparam logic [CW-1:0] LOSEM = CW'(LOSE_M);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  state_e        state_q, state_d;
  logic [CW-1:0] el_q, el_d;
  logic          chan_y_q, chan_y_d;
  logic [CW-1:0] period_q, period_d;
  logic [CW-1:0] t1_q, t1_d;
  logic [CW-1:0] t2_q, t2_d;
  logic [CW-1:0] t3_q, t3_d;
  logic [CW-1:0] range_cnt_q, range_cnt_d;
  logic          range_valid_q, range_valid_d;
  logic          locked_q, locked_d;
  logic          gen_resetn_q, gen_resetn_d;
  logic [CW-1:0] hit_run_q, hit_run_d;
  logic [CW-1:0] miss_run_q, miss_run_d;
  logic          tx_entry, hit, miss, clr_lock;
  logic [CW-1:0] tx_last;

  // Last TX cycle index: PULSE_W + spacing, giving PULSE_W+spacing+1 TX cycles.
  assign tx_last = PW + (chan_y_q ? YSP : XSP);

  always_comb begin
    state_d       = state_q;
    el_d          = sat_inc(el_q);
    chan_y_d      = chan_y_q;
    period_d      = period_q;
    t1_d          = t1_q;
    t2_d          = t2_q;
    t3_d          = t3_q;
    range_cnt_d   = range_cnt_q;
    range_valid_d = 1'b0;
    hit_run_d     = hit_run_q;
    miss_run_d    = miss_run_q;
    locked_d      = locked_q;
    tx_entry      = 1'b0;
    hit           = 1'b0;
    miss          = 1'b0;
    clr_lock      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (enable) tx_entry = 1'b1;
      end
      S_TX: begin
        if (el_q == tx_last) state_d = S_LISTEN;
      end
      S_LISTEN: begin
        if (reply_det) begin
          range_cnt_d   = el_q;
          range_valid_d = 1'b1;
          hit           = 1'b1;
          state_d       = S_WAIT;
        end else if (el_q == LMAX - 1'b1) begin
          miss    = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (el_q == period_q - 1'b1) begin
          if (enable) begin
            tx_entry = 1'b1;
          end else begin
            state_d  = S_IDLE;
            clr_lock = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Period is frozen here so a lock change only affects the next cycle.
    if (tx_entry) begin
      state_d  = S_TX;
      el_d     = '0;
      chan_y_d = chan_y;
      t2_d     = (chan_y ? YSP : XSP) - PW;
      period_d = locked_q ? TPER : SPER;
    end

    if (hit) begin
      hit_run_d  = sat_inc(hit_run_q);
      miss_run_d = '0;
    end else if (miss) begin
      miss_run_d = sat_inc(miss_run_q);
      hit_run_d  = '0;
    end

    if (!locked_q && hit_run_d >= LOCKN) begin
      locked_d = 1'b1;
    end else if (locked_q && miss_run_d >= LOSEM) begin
      locked_d   = 1'b0;
      hit_run_d  = '0;
      miss_run_d = '0;
    end

    if (clr_lock) begin
      locked_d   = 1'b0;
      hit_run_d  = '0;
      miss_run_d = '0;
    end

    gen_resetn_d = (state_d == S_TX);
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= S_IDLE;
      el_q          <= '0;
      chan_y_q      <= 1'b0;
      period_q      <= SPER;
      t1_q          <= PW;
      t2_q          <= XSP - PW;
      t3_q          <= '1;
      range_cnt_q   <= '0;
      range_valid_q <= 1'b0;
      locked_q      <= 1'b0;
      gen_resetn_q  <= 1'b0;
      hit_run_q     <= '0;
      miss_run_q    <= '0;
    end else begin
      state_q       <= state_d;
      el_q          <= el_d;
      chan_y_q      <= chan_y_d;
      period_q      <= period_d;
      t1_q          <= t1_d;
      t2_q          <= t2_d;
      t3_q          <= t3_d;
      range_cnt_q   <= range_cnt_d;
      range_valid_q <= range_valid_d;
      locked_q      <= locked_d;
      gen_resetn_q  <= gen_resetn_d;
      hit_run_q     <= hit_run_d;
      miss_run_q    <= miss_run_d;
    end
  end

  always_ff @(posedge clk) begin
    assert (PULSE_W < X_SPACING && PULSE_W < Y_SPACING)
      else $error("pulse width must be shorter than both spacings");
    assert (LISTEN_MAX < SEARCH_PERIOD && SEARCH_PERIOD <= TRACK_PERIOD)
      else $error("listen window must fit inside the search period");
    assert (PULSE_W + X_SPACING + 1 < LISTEN_MAX && PULSE_W + Y_SPACING + 1 < LISTEN_MAX)
      else $error("TX length must be shorter than the listen window");
  end

  assign gen_resetn  = gen_resetn_q;
  assign t1          = t1_q;
  assign t2          = t2_q;
  assign t3          = t3_q;
  assign range_cnt   = range_cnt_q;
  assign range_valid = range_valid_q;
  assign locked      = locked_q;

endmodule

// File: tb/tb_dme_interrogation_scheduler.sv
// Bench for dme_interrogation_scheduler: interrogation-level reference model
// compared every cycle, plus directed cycles with hand-computed expectations.
module tb_dme_interrogation_scheduler;

  localparam int CW = 32;
  localparam int PULSE_W = 3, X_SPACING = 6, Y_SPACING = 10;
  localparam int SEARCH_PERIOD = 40, TRACK_PERIOD = 80, LISTEN_MAX = 30;
  localparam int LOCK_N = 2, LOSE_M = 3;

  logic          clk, resetn, enable, chan_y, reply_det;
  logic          gen_resetn, range_valid, locked;
  logic [CW-1:0] t1, t2, t3, range_cnt;

  dme_interrogation_scheduler #(
    .CW(CW), .PULSE_W(PULSE_W), .X_SPACING(X_SPACING), .Y_SPACING(Y_SPACING),
    .SEARCH_PERIOD(SEARCH_PERIOD), .TRACK_PERIOD(TRACK_PERIOD),
    .LISTEN_MAX(LISTEN_MAX), .LOCK_N(LOCK_N), .LOSE_M(LOSE_M)
  ) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .chan_y(chan_y),
    .reply_det(reply_det), .gen_resetn(gen_resetn), .t1(t1), .t2(t2), .t3(t3),
    .range_cnt(range_cnt), .range_valid(range_valid), .locked(locked)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
  endtask

  // Reference model: one interrogation = TX entry time + period; outputs
  // derive from the phase (cycles since entry) of the cycle being modelled.
  bit m_active, m_done, m_lk, chk_en, go, old_lk;
  int m_start, m_txlen, m_period, m_hits, m_miss, ph, sp, cyc;
  bit e_gen, e_rv, e_lk;
  int e_t2, e_rc;

  initial begin
    cyc = 0; chk_en = 0; m_active = 0; m_lk = 0; m_hits = 0; m_miss = 0;
    m_start = 0; m_txlen = 0; m_period = 0; m_done = 0;
    forever begin
      @(posedge clk);
      if (!resetn) begin
        m_active = 0; m_lk = 0; m_hits = 0; m_miss = 0;
        e_gen = 0; e_t2 = X_SPACING - PULSE_W; e_rc = 0; e_rv = 0; e_lk = 0;
        chk_en = 1;
      end else begin
        go = 0; old_lk = m_lk; e_rv = 0;
        if (!m_active) go = enable;
        else begin
          ph = cyc - m_start;
          if (!m_done && ph >= m_txlen) begin
            if (reply_det) begin
              e_rc = ph; e_rv = 1; m_done = 1;
              m_hits++; m_miss = 0;
              if (!m_lk && m_hits >= LOCK_N) m_lk = 1;
            end else if (ph == LISTEN_MAX - 1) begin
              m_done = 1; m_miss++; m_hits = 0;
              if (m_lk && m_miss >= LOSE_M) begin m_lk = 0; m_hits = 0; m_miss = 0; end
            end
          end
          if (ph == m_period - 1) begin
            if (enable) go = 1;
            else begin m_active = 0; m_lk = 0; m_hits = 0; m_miss = 0; end
          end
        end
        if (go) begin
          m_active = 1; m_start = cyc + 1; m_done = 0;
          sp = chan_y ? Y_SPACING : X_SPACING;
          m_txlen = PULSE_W + sp + 1;
          e_t2 = sp - PULSE_W;
          m_period = old_lk ? TRACK_PERIOD : SEARCH_PERIOD;
        end
        e_gen = m_active && (cyc + 1 - m_start < m_txlen);
        e_lk = m_lk;
      end
      cyc++;
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        chk("m_gen_resetn", gen_resetn, e_gen);
        chk("m_t1", t1, PULSE_W);
        chk("m_t2", t2, e_t2);
        chk("m_t3", t3, {32'hFFFF_FFFF});
        chk("m_range_cnt", range_cnt, e_rc);
        chk("m_range_valid", range_valid, e_rv);
        chk("m_locked", locked, e_lk);
      end
    end
  end

  task automatic wait_entry(output bit ok);
    logic prev;
    prev = gen_resetn;
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (gen_resetn === 1'b1 && prev !== 1'b1) begin ok = 1; break; end
      prev = gen_resetn;
    end
  endtask

  // Called at the negedge of a TX entry cycle; ends at the next entry's negedge.
  task automatic do_cycle(input int r1, input int r2, input int r3, input int drop,
                          input bit nxt, input int maxc,
                          output int hi, output int rv, output int rc, output int len);
    logic prev;
    hi = 0; rv = 0; rc = -1; len = 0; prev = 1'b0;
    chan_y = nxt;
    for (int el = 0; el < maxc; el++) begin
      if (el > 0 && gen_resetn === 1'b1 && prev === 1'b0) begin len = el; break; end
      if (gen_resetn === 1'b1) hi++;
      if (range_valid === 1'b1) begin rv++; rc = int'(range_cnt); end
      prev = gen_resetn;
      @(posedge clk); #1;
      reply_det = (el + 1 == r1) || (el + 1 == r2) || (el + 1 == r3);
      if (el + 1 == drop) enable = 1'b0;
      @(negedge clk);
    end
    reply_det = 1'b0;
  endtask

  bit ok;
  int hi, rv, rc, len;

  initial begin
    resetn = 1'b0; enable = 1'b0; chan_y = 1'b0; reply_det = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gen_resetn", gen_resetn, 0);
    chk("rst_t1", t1, 3);
    chk("rst_t2", t2, 3);
    chk("rst_range_cnt", range_cnt, 0);
    chk("rst_range_valid", range_valid, 0);
    chk("rst_locked", locked, 0);

    @(posedge clk); #1;
    resetn = 1'b1; enable = 1'b1; chan_y = 1'b0;
    wait_entry(ok);
    chk("c1_entry", ok, 1);
    chk("c1_t2", t2, 3);

    // X channel, reply at el=20
    do_cycle(20, -1, -1, -1, 1'b1, 100, hi, rv, rc, len);
    chk("c1_tx_len", hi, 10);
    chk("c1_rv_cnt", rv, 1);
    chk("c1_range", rc, 20);
    chk("c1_period", len, 40);
    chk("c2_t2", t2, 7);

    // Y channel: reply in TX and after the hit are ignored; second hit locks
    do_cycle(5, 18, 25, -1, 1'b0, 100, hi, rv, rc, len);
    chk("c2_tx_len", hi, 14);
    chk("c2_rv_cnt", rv, 1);
    chk("c2_range", rc, 18);
    chk("c2_period", len, 40);
    chk("c2_locked", locked, 1);

    // Three silent cycles while locked at the track period
    do_cycle(-1, -1, -1, -1, 1'b0, 120, hi, rv, rc, len);
    chk("c3_rv_cnt", rv, 0);
    chk("c3_period", len, 80);
    chk("c3_locked", locked, 1);
    do_cycle(-1, -1, -1, -1, 1'b0, 120, hi, rv, rc, len);
    chk("c4_period", len, 80);
    do_cycle(-1, -1, -1, -1, 1'b0, 120, hi, rv, rc, len);
    chk("c5_tx_len", hi, 10);
    chk("c5_period", len, 80);
    chk("c5_unlocked", locked, 0);

    // Reply on the last listen cycle still counts as a hit
    do_cycle(29, -1, -1, -1, 1'b0, 100, hi, rv, rc, len);
    chk("c6_rv_cnt", rv, 1);
    chk("c6_range", rc, 29);
    chk("c6_period", len, 40);

    // Second hit locks, then enable drops mid-WAIT: cycle ends, lock cleared
    do_cycle(21, -1, -1, 25, 1'b1, 60, hi, rv, rc, len);
    chk("c7_range", rc, 21);
    chk("c7_no_next_tx", len, 0);
    chk("c7_idle_locked", locked, 0);
    chk("c7_idle_gen", gen_resetn, 0);

    // Reset in the middle of a Y-channel TX
    @(posedge clk); #1;
    enable = 1'b1;
    wait_entry(ok);
    chk("c8_entry", ok, 1);
    chk("c8_t2", t2, 7);
    repeat (3) @(posedge clk);
    #1 resetn = 1'b0; enable = 1'b0;
    @(posedge clk); #1 resetn = 1'b1;
    @(negedge clk);
    chk("c8_rst_gen", gen_resetn, 0);
    chk("c8_rst_t2", t2, 3);
    repeat (5) @(negedge clk);
    chk("c8_idle_gen", gen_resetn, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_chk);
    $fatal(1, "watchdog expired");
  end

endmodule
